// File: rtl/cordic_pkg.sv
// cordic_pkg: angle-unit constants, arctangent table and FSM state type shared by the CORDIC core.
package cordic_pkg;
   localparam int ZW_DEF  = 9;
   localparam int ZF_DEF  = 4;
   localparam int QUARTER = 128;
   localparam int HALF    = 256;
   localparam int K_Q16   = 107922;
   localparam int LUT_N   = 12;
   localparam int CW      = 4;
   // atan(2^-i) in units of 2^(ZW+ZF) per turn, tabulated at ZF=4
   localparam int ATAN_LUT [LUT_N] = '{1024, 605, 319, 162, 81, 41, 20, 10, 5, 3, 1, 1};

   typedef enum logic [1:0] {IDLE, ROT, DONE} cordic_state_t;

   function automatic int atan_at(input logic [CW-1:0] i, input int zf);
      int v;
      v = (int'(i) < LUT_N) ? ATAN_LUT[i] : 0;
      return (zf >= 4) ? (v <<< (zf - 4)) : (v >>> (4 - zf));
   endfunction
endpackage

// File: rtl/cordic_rotate_core_microrot.sv
// cordic_microrot: one combinational shift-add rotation step for stage i and direction d.
module cordic_microrot #(
   parameter int XW  = 21,
   parameter int ZIW = 13,
   parameter int CW  = 4
) (
   input  logic signed [XW-1:0]  x_i,
   input  logic signed [XW-1:0]  y_i,
   input  logic signed [ZIW-1:0] z_i,
   input  logic [CW-1:0]         i_i,
   input  logic                  neg_i,
   input  logic signed [ZIW-1:0] atan_i,
   output logic signed [XW-1:0]  x_o,
   output logic signed [XW-1:0]  y_o,
   output logic signed [ZIW-1:0] z_o
);
   logic signed [XW-1:0] xs, ys;
   assign xs  = x_i >>> i_i;
   assign ys  = y_i >>> i_i;
   assign x_o = neg_i ? x_i + ys : x_i - ys;
   assign y_o = neg_i ? y_i - xs : y_i + xs;
   assign z_o = neg_i ? z_i + atan_i : z_i - atan_i;
endmodule

// File: rtl/cordic_rotate_core.sv
// cordic_rotate_core: iterative rotation-mode CORDIC, one micro-rotation per clock,
// with valid/ready handshakes and saturated x/y outputs.
module cordic_rotate_core
   import cordic_pkg::*;
#(
   parameter int W    = 19,
   parameter int ZW   = ZW_DEF,
   parameter int ZF   = ZF_DEF,
   parameter int ITER = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic signed [W-1:0]     in_x_i,
   input  logic signed [W-1:0]     in_y_i,
   input  logic signed [ZW-1:0]    in_z_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [W-1:0]     out_x_o,
   output logic signed [W-1:0]     out_y_o,
   output logic signed [ZW+ZF-1:0] out_z_o
);
   localparam int XW  = W + 2;
   localparam int ZIW = ZW + ZF;
   localparam logic signed [XW-1:0] MAXV = XW'((1 << (W - 1)) - 1);
   localparam logic signed [XW-1:0] MINV = ~MAXV;

   generate
      if (ITER < 1 || ITER > LUT_N) begin : g_bad_iter
         $error("cordic_rotate_core: ITER must be in 1..12");
      end
   endgenerate

   cordic_state_t        state_q, state_d;
   logic [CW-1:0]        i_q, i_d;
   logic signed [XW-1:0] x_q, x_d, y_q, y_d, xn, yn;
   logic signed [ZIW-1:0] z_q, z_d, zn, atan;
   logic signed [W-1:0]  ox_q, ox_d, oy_q, oy_d;
   logic signed [ZIW-1:0] oz_q, oz_d;

   function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
      return (v > MAXV) ? W'(MAXV) : (v < MINV) ? W'(MINV) : W'(v);
   endfunction

   assign atan = ZIW'(atan_at(i_q, ZF));

   cordic_microrot #(.XW(XW), .ZIW(ZIW), .CW(CW)) u_step (
      .x_i   (x_q),
      .y_i   (y_q),
      .z_i   (z_q),
      .i_i   (i_q),
      .neg_i (z_q[ZIW-1]),
      .atan_i(atan),
      .x_o   (xn),
      .y_o   (yn),
      .z_o   (zn)
   );

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      oz_d    = oz_q;
      unique case (state_q)
         IDLE: if (in_valid_i) begin
            state_d = ROT;
            i_d     = '0;
            x_d     = {{2{in_x_i[W-1]}}, in_x_i};
            y_d     = {{2{in_y_i[W-1]}}, in_y_i};
            z_d     = {in_z_i, {ZF{1'b0}}};
         end
         ROT: begin
            x_d = xn;
            y_d = yn;
            z_d = zn;
            i_d = i_q + CW'(1);
            if (i_q == CW'(ITER - 1)) begin
               state_d = DONE;
               ox_d    = sat(xn);
               oy_d    = sat(yn);
               oz_d    = zn;
            end
         end
         DONE: state_d = out_ready_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         oz_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         oz_q    <= oz_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign out_x_o     = ox_q;
   assign out_y_o     = oy_q;
   assign out_z_o     = oz_q;
endmodule

// File: tb/tb_cordic_rotate_core.sv
// tb_cordic_rotate_core: directed vectors with hand-stepped bit-exact results for ITER=8, ZF=4.
module tb_cordic_rotate_core;
   localparam int W  = 19;
   localparam int ZW = 9;
   localparam int ZF = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid_i = 1'b0;
   logic out_ready_i = 1'b1;
   logic signed [W-1:0] in_x_i = '0;
   logic signed [W-1:0] in_y_i = '0;
   logic signed [ZW-1:0] in_z_i = '0;
   logic in_ready_o, out_valid_o;
   logic signed [W-1:0] out_x_o, out_y_o;
   logic signed [ZW+ZF-1:0] out_z_o;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cordic_rotate_core #(.W(W), .ZW(ZW), .ZF(ZF), .ITER(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_x_i     (in_x_i),
      .in_y_i     (in_y_i),
      .in_z_i     (in_z_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_x_o    (out_x_o),
      .out_y_o    (out_y_o),
      .out_z_o    (out_z_o)
   );

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic start_op(input int x, input int y, input int z);
      check("in_ready_before_op", 32'(in_ready_o), 1);
      in_x_i = W'(x);
      in_y_i = W'(y);
      in_z_i = ZW'(z);
      in_valid_i = 1'b1;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      int cyc = 1;
      while (!out_valid_o && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", cyc, 9);
   endtask

   task automatic check_out(input string tag, input int ex, input int ey, input int ez);
      check({tag, "_x"}, 32'(out_x_o), ex);
      check({tag, "_y"}, 32'(out_y_o), ey);
      check({tag, "_z"}, 32'(out_z_o), ez);
   endtask

   task automatic run_op(input string tag, input int x, input int y, input int z,
                         input int ex, input int ey, input int ez);
      start_op(x, y, z);
      wait_done();
      check_out(tag, ex, ey, ez);
      @(posedge clk);
      #1;
      check({tag, "_idle_valid"}, 32'(out_valid_o), 0);
      check({tag, "_idle_ready"}, 32'(in_ready_o), 1);
   endtask

   initial begin
      #12;
      check("rst_in_ready", 32'(in_ready_o), 1);
      check("rst_out_valid", 32'(out_valid_o), 0);
      check_out("rst", 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("zero_angle", 60000, 0, 0, 98802, 694, -8);
      run_op("deg45", 60000, 0, 64, 70363, 69365, 8);
      run_op("degm90", 60000, 0, -128, 695, -98802, -8);
      run_op("saturate", 262143, 262143, 64, 4366, 262143, 8);
      out_ready_i = 1'b0;
      start_op(60000, 0, 0);
      wait_done();
      for (int k = 0; k < 5; k++) begin
         in_valid_i = k[0];
         in_x_i = W'(1000 * k);
         in_z_i = ZW'(-64);
         @(posedge clk);
         #1;
         check("stall_valid", 32'(out_valid_o), 1);
         check("stall_ready", 32'(in_ready_o), 0);
         check_out("stall", 98802, 694, -8);
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("release_valid", 32'(out_valid_o), 0);
      check("release_ready", 32'(in_ready_o), 1);
      run_op("after_stall", 60000, 0, 64, 70363, 69365, 8);
      start_op(60000, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_abort_ready", 32'(in_ready_o), 0);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(out_valid_o), 0);
      check("abort_ready", 32'(in_ready_o), 1);
      check_out("abort", 0, 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("post_reset", 60000, 0, 0, 98802, 694, -8);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
